// File: rtl/av_mode_regs.sv
// av_mode_regs: Avalon-MM slave register bank. Every word register has its
// own access mode (RW / RO / W1C / WP). Reads return through a pipeline of
// RD_LAT stages, and the interrupt is registered.

// One register word. MODE selects how writes, hardware sets and reads act on it.
module av_mode_regs_word #(
    parameter int              DW   = 32,
    parameter logic [1:0]      MODE = 2'd0,
    parameter logic [DW-1:0]   INIT = '0
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          wr,
    input  logic          rd,
    input  logic          be_any,
    input  logic [DW-1:0] bmask,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] slv,
    input  logic [DW-1:0] hw_set,
    output logic [DW-1:0] word,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] w1c_bits,
    output logic          wr_pulse,
    output logic          rd_pulse
);
    localparam logic [1:0] M_RW  = 2'd0;
    localparam logic [1:0] M_RO  = 2'd1;
    localparam logic [1:0] M_W1C = 2'd2;
    localparam logic [1:0] M_WP  = 2'd3;

    // WP words and RO words hold no software state, so they reset to 0.
    localparam logic [DW-1:0] RST_VAL = (MODE == M_RW || MODE == M_W1C) ? INIT : '0;

    logic [DW-1:0] q;

    // Register update. In W1C mode the hardware set is ORed in last, so a
    // set wins over a clear that hits the same bit in the same cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            q <= RST_VAL;
        end else begin
            case (MODE)
                M_RW:    if (wr) q <= (q & ~bmask) | (wdata & bmask);
                M_W1C:   q <= (q & ~(wr ? (wdata & bmask) : '0)) | hw_set;
                M_WP:    q <= wr ? (wdata & bmask) : '0;
                default: q <= '0;
            endcase
        end
    end

    // Access strobes for user logic. A request with no byte lanes enabled
    // does not count as an access.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_pulse <= 1'b0;
            rd_pulse <= 1'b0;
        end else begin
            wr_pulse <= wr & be_any;
            rd_pulse <= rd & be_any;
        end
    end

    // Read value, with disabled byte lanes forced to 0. W1C returns the
    // value before this cycle's update, because q has not moved yet.
    always_comb begin
        rdata = '0;
        case (MODE)
            M_RW, M_W1C: rdata = q & bmask;
            M_RO:        rdata = slv & bmask;
            default:     rdata = '0;
        endcase
    end

    assign word     = q;
    assign w1c_bits = (MODE == M_W1C) ? q : '0;
endmodule

module av_mode_regs #(
    parameter int                             DW        = 32,
    parameter int                             AW        = 16,
    parameter int                             REGS_NUM  = 4,
    parameter logic [REGS_NUM-1:0][1:0]       REGS_MODE = '0,
    parameter logic [REGS_NUM-1:0][DW-1:0]    REGS_INIT = '0,
    parameter int                             RD_LAT    = 1,
    parameter logic [31:0]                    ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [AW-1:0]          avms_address,
    input  logic [DW/8-1:0]        avms_byteenable,
    input  logic                   avms_read,
    input  logic                   avms_write,
    input  logic [DW-1:0]          avms_writedata,
    output logic [DW-1:0]          avms_readdata,
    output logic                   avms_readdatavalid,
    output logic [1:0]             avms_response,
    output logic [REGS_NUM*DW-1:0] mst_word_o,
    input  logic [REGS_NUM*DW-1:0] slv_word_i,
    input  logic [REGS_NUM*DW-1:0] hw_set_i,
    output logic [REGS_NUM-1:0]    word_valid_wr_o,
    output logic [REGS_NUM-1:0]    word_valid_rd_o,
    output logic                   irq_o
);
    localparam int            BW       = DW / 8;
    localparam logic [DW-1:0] ERR_DATA = DW'(ERR_RDATA);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rd_rsp_t;

    logic [DW-1:0]                bmask;
    logic                         in_range;
    logic                         rd_en;
    logic                         be_any;
    logic [REGS_NUM-1:0]          sel;
    logic [REGS_NUM-1:0][DW-1:0]  word_arr;
    logic [REGS_NUM-1:0][DW-1:0]  rdata_arr;
    logic [REGS_NUM-1:0][DW-1:0]  w1c_arr;
    logic [REGS_NUM-1:0]          wr_pulse_arr;
    logic [REGS_NUM-1:0]          rd_pulse_arr;
    logic [DW-1:0]                rsel;
    rd_rsp_t                      acc_rsp;
    rd_rsp_t                      rsp_pipe [RD_LAT:1];
    logic [RD_LAT:1]              vld_pipe;

    // Expand the byte enables into a bit mask.
    always_comb begin
        bmask = '0;
        for (int b = 0; b < BW; b++) bmask[b*8 +: 8] = {8{avms_byteenable[b]}};
    end

    // A write takes priority over a simultaneous read; that read is dropped.
    assign rd_en    = avms_read & ~avms_write;
    assign be_any   = |avms_byteenable;
    assign in_range = {1'b0, avms_address} < (AW+1)'(REGS_NUM);

    for (genvar i = 0; i < REGS_NUM; i++) begin : g_word
        assign sel[i] = in_range && (avms_address == AW'(i));

        av_mode_regs_word #(
            .DW   (DW),
            .MODE (REGS_MODE[i]),
            .INIT (REGS_INIT[i])
        ) u_word (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .wr        (avms_write & sel[i]),
            .rd        (rd_en & sel[i]),
            .be_any    (be_any),
            .bmask     (bmask),
            .wdata     (avms_writedata),
            .slv       (slv_word_i[i*DW +: DW]),
            .hw_set    (hw_set_i[i*DW +: DW]),
            .word      (word_arr[i]),
            .rdata     (rdata_arr[i]),
            .w1c_bits  (w1c_arr[i]),
            .wr_pulse  (wr_pulse_arr[i]),
            .rd_pulse  (rd_pulse_arr[i])
        );
    end

    assign mst_word_o      = word_arr;
    assign word_valid_wr_o = wr_pulse_arr;
    assign word_valid_rd_o = rd_pulse_arr;

    // Read mux. Select is one-hot, or all zero when the address is out of range.
    always_comb begin
        rsel = '0;
        for (int i = 0; i < REGS_NUM; i++) if (sel[i]) rsel = rsel | rdata_arr[i];
        acc_rsp.data = in_range ? rsel  : ERR_DATA;
        acc_rsp.resp = in_range ? 2'b00 : 2'b11;
    end

    // Read return pipeline. A stage loads only when valid data arrives, so
    // the last stage, and with it readdata, holds between responses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            vld_pipe <= '0;
            for (int k = 1; k <= RD_LAT; k++) rsp_pipe[k] <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            if (rd_en) rsp_pipe[1] <= acc_rsp;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) rsp_pipe[k] <= rsp_pipe[k-1];
            end
        end
    end

    assign avms_readdata      = rsp_pipe[RD_LAT].data;
    assign avms_response      = rsp_pipe[RD_LAT].resp;
    assign avms_readdatavalid = vld_pipe[RD_LAT];

    // Interrupt: registered OR of every W1C bit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) irq_o <= 1'b0;
        else            irq_o <= |w1c_arr;
    end
endmodule

// File: tb/tb_av_mode_regs.sv
// Bench for av_mode_regs. Registers: 0 RW (init 1234_5678), 1 RO, 2 W1C,
// 3 WP. RD_LAT is 2. Directed scenarios come first, then randomized
// traffic, all checked against a word-level model of the register map.
module tb_av_mode_regs;
    localparam int          DW     = 32;
    localparam int          AW     = 16;
    localparam int          N      = 4;
    localparam int          RD_LAT = 2;
    localparam logic [31:0] INIT0  = 32'h1234_5678;

    logic            clk_i = 1'b0;
    logic            reset_n_i = 1'b0;
    logic [AW-1:0]   avms_address;
    logic [DW/8-1:0] avms_byteenable;
    logic            avms_read;
    logic            avms_write;
    logic [DW-1:0]   avms_writedata;
    logic [DW-1:0]   avms_readdata;
    logic            avms_readdatavalid;
    logic [1:0]      avms_response;
    logic [N*DW-1:0] mst_word_o;
    logic [N*DW-1:0] slv_word_i;
    logic [N*DW-1:0] hw_set_i;
    logic [N-1:0]    word_valid_wr_o;
    logic [N-1:0]    word_valid_rd_o;
    logic            irq_o;

    always #5 clk_i = ~clk_i;

    av_mode_regs #(
        .DW        (DW),
        .AW        (AW),
        .REGS_NUM  (N),
        .REGS_MODE ({2'd3, 2'd2, 2'd1, 2'd0}),
        .REGS_INIT ({32'h0, 32'h0, 32'h0, INIT0}),
        .RD_LAT    (RD_LAT),
        .ERR_RDATA (32'hDEAD_BEEF)
    ) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .avms_address       (avms_address),
        .avms_byteenable    (avms_byteenable),
        .avms_read          (avms_read),
        .avms_write         (avms_write),
        .avms_writedata     (avms_writedata),
        .avms_readdata      (avms_readdata),
        .avms_readdatavalid (avms_readdatavalid),
        .avms_response      (avms_response),
        .mst_word_o         (mst_word_o),
        .slv_word_i         (slv_word_i),
        .hw_set_i           (hw_set_i),
        .word_valid_wr_o    (word_valid_wr_o),
        .word_valid_rd_o    (word_valid_rd_o),
        .irq_o              (irq_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    exp_t        exq[$];
    logic [31:0] m_reg [N];
    logic [31:0] m_wp;
    logic        m_irq;
    logic [3:0]  m_wrp, m_rdp;
    logic        exp_vld;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic logic [31:0] mw(int i);
        return mst_word_o[i*32 +: 32];
    endfunction

    task automatic model_reset();
        exq.delete();
        m_reg[0] = INIT0; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0;
        m_wp = 0; m_irq = 0; m_wrp = 0; m_rdp = 0;
        exp_vld = 0; exp_rdata = 0; exp_resp = 0;
    endtask

    task automatic set_idle();
        avms_read = 0; avms_write = 0; avms_address = 0;
        avms_byteenable = 4'hF; avms_writedata = 0; hw_set_i = '0;
    endtask

    task automatic drive(input bit rd, input bit wr, input int addr,
                         input logic [3:0] be, input logic [31:0] wd);
        avms_read = rd; avms_write = wr; avms_address = AW'(addr);
        avms_byteenable = be; avms_writedata = wd;
    endtask

    // Work out the model's next state from the current inputs, then advance
    // one clock and sample at 1 ns past the edge.
    task automatic tick();
        logic [31:0] mask, wd, rv, n_wp;
        logic [3:0]  n_wrp, n_rdp;
        logic        rd, inr, n_irq;
        int          a;
        exp_t        e;
        for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{avms_byteenable[b]}};
        a     = int'(avms_address);
        inr   = (a < N);
        rd    = avms_read && !avms_write;
        n_wrp = '0;
        n_rdp = '0;
        if (avms_write && inr && avms_byteenable != 0) n_wrp[a] = 1'b1;
        if (rd && inr && avms_byteenable != 0)         n_rdp[a] = 1'b1;
        if (rd) begin
            case (a)
                0:       rv = m_reg[0];
                1:       rv = slv_word_i[63:32];
                2:       rv = m_reg[2];
                default: rv = 32'h0;
            endcase
            e.due = cyc + RD_LAT;
            e.d   = inr ? (rv & mask) : 32'hDEAD_BEEF;
            e.r   = inr ? 2'b00 : 2'b11;
            exq.push_back(e);
        end
        n_irq = |m_reg[2];
        wd    = avms_writedata & mask;
        if (avms_write && a == 0) m_reg[0] = (m_reg[0] & ~mask) | wd;
        m_reg[2] = (m_reg[2] & ~((avms_write && a == 2) ? wd : 32'h0)) | hw_set_i[95:64];
        n_wp  = (avms_write && a == 3) ? wd : 32'h0;
        @(posedge clk_i); #1;
        cyc++;
        m_wrp = n_wrp; m_rdp = n_rdp; m_irq = n_irq; m_wp = n_wp;
        exp_vld = 1'b0;
        if (exq.size() > 0 && exq[0].due == cyc) begin
            exp_vld   = 1'b1;
            exp_rdata = exq[0].d;
            exp_resp  = exq[0].r;
            void'(exq.pop_front());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_chk++; if (avms_readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %b want 0", avms_readdatavalid); else n_pass++;
        n_chk++; if (avms_readdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", avms_readdata); else n_pass++;
        n_chk++; if (avms_response !== 2'b00) $display("FAIL reset_resp: got %b want 00", avms_response); else n_pass++;
        n_chk++; if ({word_valid_wr_o, word_valid_rd_o, irq_o} !== 9'h0) $display("FAIL reset_pulses_irq: got %h want 0", {word_valid_wr_o, word_valid_rd_o, irq_o}); else n_pass++;
        n_chk++; if (mw(0) !== INIT0) $display("FAIL reset_mst0: got %h want %h", mw(0), INIT0); else n_pass++;
        n_chk++; if (mw(3) !== 32'h0) $display("FAIL reset_mst3: got %h want 0", mw(3)); else n_pass++;
        reset_n_i = 1'b1;
        drive(1, 0, 0, 4'hF, 0);
        tick();
        set_idle();
        n_chk++; if (avms_readdatavalid !== 1'b0) $display("FAIL rd_lat_early: got %b want 0", avms_readdatavalid); else n_pass++;
        n_chk++; if (word_valid_rd_o !== 4'b0001) $display("FAIL rd_pulse0: got %b want 0001", word_valid_rd_o); else n_pass++;
        tick();
        n_chk++; if (avms_readdatavalid !== 1'b1) $display("FAIL rd_lat_valid: got %b want 1", avms_readdatavalid); else n_pass++;
        n_chk++; if (avms_readdata !== INIT0) $display("FAIL rd_init_data: got %h want %h", avms_readdata, INIT0); else n_pass++;
        n_chk++; if (avms_response !== 2'b00) $display("FAIL rd_init_resp: got %b want 00", avms_response); else n_pass++;
        tick();
        n_chk++; if (avms_readdatavalid !== 1'b0) $display("FAIL rd_single_cycle: got %b want 0", avms_readdatavalid); else n_pass++;
    endtask

    task automatic test_rw_byteenable();
        drive(0, 1, 0, 4'b0101, 32'hAABB_CCDD);
        tick();
        set_idle();
        n_chk++; if (word_valid_wr_o !== 4'b0001) $display("FAIL rw_wr_pulse: got %b want 0001", word_valid_wr_o); else n_pass++;
        n_chk++; if (mw(0) !== 32'h12BB_56DD) $display("FAIL rw_be_mst: got %h want 12bb56dd", mw(0)); else n_pass++;
        drive(1, 0, 0, 4'hF, 0);
        tick();
        set_idle();
        n_chk++; if (word_valid_wr_o !== 4'b0000) $display("FAIL rw_wr_pulse_end: got %b want 0000", word_valid_wr_o); else n_pass++;
        tick();
        n_chk++; if (avms_readdata !== 32'h12BB_56DD || avms_readdatavalid !== 1'b1) $display("FAIL rw_be_read: got %h/%b want 12bb56dd/1", avms_readdata, avms_readdatavalid); else n_pass++;
    endtask

    task automatic test_w1c();
        hw_set_i[64+3] = 1'b1;
        tick();
        hw_set_i = '0;
        n_chk++; if (mw(2) !== 32'h8) $display("FAIL w1c_set: got %h want 8", mw(2)); else n_pass++;
        n_chk++; if (irq_o !== 1'b0) $display("FAIL w1c_irq_lag: got %b want 0", irq_o); else n_pass++;
        drive(1, 0, 2, 4'hF, 0);
        tick();
        set_idle();
        n_chk++; if (irq_o !== 1'b1) $display("FAIL w1c_irq_rise: got %b want 1", irq_o); else n_pass++;
        tick();
        n_chk++; if (avms_readdata !== 32'h8 || avms_readdatavalid !== 1'b1) $display("FAIL w1c_read: got %h/%b want 8/1", avms_readdata, avms_readdatavalid); else n_pass++;
        drive(0, 1, 2, 4'hF, 32'h8);
        hw_set_i[64+3] = 1'b1;
        tick();
        hw_set_i = '0;
        n_chk++; if (mw(2) !== 32'h8) $display("FAIL w1c_set_wins: got %h want 8", mw(2)); else n_pass++;
        drive(0, 1, 2, 4'hF, 32'h8);
        tick();
        set_idle();
        n_chk++; if (mw(2) !== 32'h0) $display("FAIL w1c_clear: got %h want 0", mw(2)); else n_pass++;
        n_chk++; if (irq_o !== 1'b1) $display("FAIL w1c_irq_hold: got %b want 1", irq_o); else n_pass++;
        tick();
        n_chk++; if (irq_o !== 1'b0) $display("FAIL w1c_irq_fall: got %b want 0", irq_o); else n_pass++;
    endtask

    task automatic test_wp();
        drive(0, 1, 3, 4'hF, 32'h0000_0001);
        tick();
        set_idle();
        n_chk++; if (mw(3) !== 32'h1) $display("FAIL wp_pulse: got %h want 1", mw(3)); else n_pass++;
        n_chk++; if (word_valid_wr_o !== 4'b1000) $display("FAIL wp_wr_pulse: got %b want 1000", word_valid_wr_o); else n_pass++;
        drive(1, 0, 3, 4'hF, 0);
        tick();
        set_idle();
        n_chk++; if (mw(3) !== 32'h0) $display("FAIL wp_clear: got %h want 0", mw(3)); else n_pass++;
        tick();
        n_chk++; if (avms_readdata !== 32'h0 || avms_readdatavalid !== 1'b1) $display("FAIL wp_read: got %h/%b want 0/1", avms_readdata, avms_readdatavalid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        slv_word_i[63:32] = 32'hCAFE_F00D;
        drive(1, 0, 1, 4'hF, 0);
        tick();
        n_chk++; if (avms_readdatavalid !== 1'b0) $display("FAIL b2b_early: got %b want 0", avms_readdatavalid); else n_pass++;
        n_chk++; if (word_valid_rd_o !== 4'b0010) $display("FAIL b2b_rd_pulse1: got %b want 0010", word_valid_rd_o); else n_pass++;
        drive(1, 0, 7, 4'hF, 0);
        tick();
        n_chk++; if ({avms_readdatavalid, avms_readdata, avms_response} !== {1'b1, 32'hCAFE_F00D, 2'b00}) $display("FAIL b2b_ro: got %b/%h/%b want 1/cafef00d/00", avms_readdatavalid, avms_readdata, avms_response); else n_pass++;
        n_chk++; if (word_valid_rd_o !== 4'b0000) $display("FAIL b2b_oor_no_pulse: got %b want 0000", word_valid_rd_o); else n_pass++;
        drive(1, 0, 0, 4'hF, 0);
        tick();
        set_idle();
        n_chk++; if ({avms_readdatavalid, avms_readdata, avms_response} !== {1'b1, 32'hDEAD_BEEF, 2'b11}) $display("FAIL b2b_oor: got %b/%h/%b want 1/deadbeef/11", avms_readdatavalid, avms_readdata, avms_response); else n_pass++;
        tick();
        n_chk++; if ({avms_readdatavalid, avms_readdata, avms_response} !== {1'b1, 32'h12BB_56DD, 2'b00}) $display("FAIL b2b_rw: got %b/%h/%b want 1/12bb56dd/00", avms_readdatavalid, avms_readdata, avms_response); else n_pass++;
        tick();
        n_chk++; if (avms_readdatavalid !== 1'b0 || avms_readdata !== 32'h12BB_56DD) $display("FAIL b2b_hold: got %b/%h want 0/12bb56dd", avms_readdatavalid, avms_readdata); else n_pass++;
    endtask

    task automatic test_rw_collision();
        drive(1, 1, 0, 4'hF, 32'h0F0F_0F0F);
        tick();
        set_idle();
        n_chk++; if (word_valid_wr_o !== 4'b0001 || word_valid_rd_o !== 4'b0000) $display("FAIL coll_pulses: got %b/%b want 0001/0000", word_valid_wr_o, word_valid_rd_o); else n_pass++;
        n_chk++; if (mw(0) !== 32'h0F0F_0F0F) $display("FAIL coll_write: got %h want 0f0f0f0f", mw(0)); else n_pass++;
        tick();
        n_chk++; if (avms_readdatavalid !== 1'b0) $display("FAIL coll_no_rdv1: got %b want 0", avms_readdatavalid); else n_pass++;
        tick();
        n_chk++; if (avms_readdatavalid !== 1'b0) $display("FAIL coll_no_rdv2: got %b want 0", avms_readdatavalid); else n_pass++;
    endtask

    task automatic test_random();
        int op;
        for (int c = 0; c < 300; c++) begin
            op = int'($urandom_range(0, 3));
            avms_read       = (op == 1 || op == 3);
            avms_write      = (op == 2 || op == 3);
            avms_address    = AW'($urandom_range(0, 7));
            avms_byteenable = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            avms_writedata  = $urandom;
            for (int w = 0; w < N; w++) begin
                slv_word_i[w*32 +: 32] = $urandom;
                hw_set_i[w*32 +: 32]   = $urandom & $urandom & $urandom;
            end
            tick();
            n_chk++; if (avms_readdatavalid !== exp_vld) $display("FAIL rnd_rdv c%0d: got %b want %b", c, avms_readdatavalid, exp_vld); else n_pass++;
            n_chk++; if (avms_readdata !== exp_rdata) $display("FAIL rnd_rdata c%0d: got %h want %h", c, avms_readdata, exp_rdata); else n_pass++;
            if (exp_vld) begin
                n_chk++; if (avms_response !== exp_resp) $display("FAIL rnd_resp c%0d: got %b want %b", c, avms_response, exp_resp); else n_pass++;
            end
            n_chk++; if (word_valid_wr_o !== m_wrp) $display("FAIL rnd_wr_pulse c%0d: got %b want %b", c, word_valid_wr_o, m_wrp); else n_pass++;
            n_chk++; if (word_valid_rd_o !== m_rdp) $display("FAIL rnd_rd_pulse c%0d: got %b want %b", c, word_valid_rd_o, m_rdp); else n_pass++;
            n_chk++; if (irq_o !== m_irq) $display("FAIL rnd_irq c%0d: got %b want %b", c, irq_o, m_irq); else n_pass++;
            n_chk++; if (mw(0) !== m_reg[0]) $display("FAIL rnd_rw c%0d: got %h want %h", c, mw(0), m_reg[0]); else n_pass++;
            n_chk++; if (mw(2) !== m_reg[2]) $display("FAIL rnd_w1c c%0d: got %h want %h", c, mw(2), m_reg[2]); else n_pass++;
            n_chk++; if (mw(3) !== m_wp) $display("FAIL rnd_wp c%0d: got %h want %h", c, mw(3), m_wp); else n_pass++;
        end
        set_idle();
    endtask

    task automatic test_reset_midflight();
        hw_set_i[64+5] = 1'b1;
        drive(1, 0, 0, 4'hF, 0);
        tick();
        set_idle();
        reset_n_i = 1'b0;
        #1;
        n_chk++; if (avms_readdatavalid !== 1'b0 || avms_readdata !== 32'h0 || avms_response !== 2'b00) $display("FAIL mid_rst_out: got %b/%h/%b want 0/0/00", avms_readdatavalid, avms_readdata, avms_response); else n_pass++;
        n_chk++; if ({word_valid_wr_o, word_valid_rd_o, irq_o} !== 9'h0) $display("FAIL mid_rst_pulses: got %h want 0", {word_valid_wr_o, word_valid_rd_o, irq_o}); else n_pass++;
        n_chk++; if (mw(0) !== INIT0 || mw(2) !== 32'h0 || mw(3) !== 32'h0) $display("FAIL mid_rst_regs: got %h/%h/%h want %h/0/0", mw(0), mw(2), mw(3), INIT0); else n_pass++;
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            n_chk++; if (avms_readdatavalid !== 1'b0) $display("FAIL mid_rst_flush c%0d: got %b want 0", c, avms_readdatavalid); else n_pass++;
        end
        n_chk++; if (mw(0) !== INIT0 || irq_o !== 1'b0) $display("FAIL mid_rst_after: got %h/%b want %h/0", mw(0), irq_o, INIT0); else n_pass++;
    endtask

    initial begin
        set_idle();
        slv_word_i = '0;
        model_reset();
        reset_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        test_rw_byteenable();
        test_w1c();
        test_wp();
        test_back_to_back();
        test_rw_collision();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
